// File: rtl/sw_debounce_reader.sv
// sw_debounce_reader
//
// Samples raw board switches/buttons, synchronises each bit through two
// flops, and debounces each bit with its own counter. A new level is
// accepted only after it has differed from the accepted level for
// DB_CYCLES consecutive clock edges. A 0->1 acceptance (a press) sets a
// sticky event flag that register logic clears with a write-1-to-clear
// strobe. irq is the enabled OR of all pending events.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   sw_in      raw asynchronous levels, 1 = pressed/on
//   event_clr  per-bit clear of sw_event, sampled every edge
//   irq_en     interrupt enable
//   sw_state   debounced level (registered)
//   sw_event   sticky press flags (registered)
//   irq        irq_en & |sw_event (combinational from registers)

module sw_debounce_reader #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [WIDTH-1:0] event_clr,
  input  logic             irq_en,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_event,
  output logic             irq
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  // accept: this edge completes the debounce window for the bit
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] press;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s2[i] != sw_state[i]) && (cnt[i] == CNT_LAST);
    end
    press = accept & s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      sw_state <= '0;
      sw_event <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        // any cycle where the synchronised input matches restarts the window
        if (s2[i] == sw_state[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          sw_state[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      // a press arriving on the same edge as its clear must not be lost
      sw_event <= (sw_event & ~event_clr) | press;
    end
  end

  assign irq = irq_en & (|sw_event);

endmodule

// File: tb/tb_sw_debounce_reader.sv
module tb_sw_debounce_reader;

  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] event_clr;
  logic             irq_en;
  logic [WIDTH-1:0] sw_state;
  logic [WIDTH-1:0] sw_event;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  sw_debounce_reader #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .event_clr (event_clr),
    .irq_en    (irq_en),
    .sw_state  (sw_state),
    .sw_event  (sw_event),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse(input logic [WIDTH-1:0] m);
    event_clr = m;
    step(1);
    event_clr = '0;
  endtask

  initial begin
    rst       = 1'b1;
    sw_in     = 8'hFF;
    event_clr = '0;
    irq_en    = 1'b0;

    // reset held with all inputs high
    step(1);
    check("rst1_state", sw_state, 8'h00);
    check("rst1_event", sw_event, 8'h00);
    check("rst1_irq",   irq,      1'b0);
    step(1);
    check("rst2_state", sw_state, 8'h00);
    check("rst2_event", sw_event, 8'h00);
    rst = 1'b0;
    step(5);
    check("rel_e5_state", sw_state, 8'h00);
    check("rel_e5_event", sw_event, 8'h00);
    step(1);
    check("rel_e6_state", sw_state, 8'hFF);
    check("rel_e6_event", sw_event, 8'hFF);
    clr_pulse(8'hFF);
    check("rel_clr_event", sw_event, 8'h00);
    sw_in = 8'h00;
    step(6);
    check("rel_off_state", sw_state, 8'h00);
    check("rel_off_event", sw_event, 8'h00);

    // clean press and release on bit 3
    irq_en = 1'b1;
    sw_in  = 8'h08;
    step(5);
    check("b3_e5_state", sw_state, 8'h00);
    check("b3_e5_irq",   irq,      1'b0);
    step(1);
    check("b3_e6_state", sw_state, 8'h08);
    check("b3_e6_event", sw_event, 8'h08);
    check("b3_e6_irq",   irq,      1'b1);
    sw_in = 8'h00;
    step(5);
    check("b3_rel_e5_state", sw_state, 8'h08);
    step(1);
    check("b3_rel_e6_state", sw_state, 8'h00);
    check("b3_rel_event",    sw_event, 8'h08);
    clr_pulse(8'h08);
    check("b3_clr_event", sw_event, 8'h00);
    check("b3_clr_irq",   irq,      1'b0);

    // glitch rejection on bit 0: 1, 2, 3 cycle pulses
    for (int p = 1; p <= 3; p++) begin
      sw_in = 8'h01;
      step(p);
      sw_in = 8'h00;
      step(1);
    end
    step(4);
    check("glitch_state", sw_state, 8'h00);
    check("glitch_event", sw_event, 8'h00);
    sw_in = 8'h01;
    step(5);
    check("hold_e5_state", sw_state, 8'h00);
    step(1);
    check("hold_e6_state", sw_state, 8'h01);
    check("hold_e6_event", sw_event, 8'h01);
    sw_in = 8'h00;
    step(6);
    clr_pulse(8'h01);
    check("hold_clr_event", sw_event, 8'h00);

    // clear vs set on bit 5
    sw_in = 8'h20;
    step(6);
    check("b5_event", sw_event, 8'h20);
    check("b5_irq",   irq,      1'b1);
    clr_pulse(8'h20);
    check("b5_clr_event", sw_event, 8'h00);
    check("b5_clr_irq",   irq,      1'b0);
    sw_in = 8'h00;
    step(6);
    check("b5_rel_state", sw_state, 8'h00);
    sw_in = 8'h20;
    step(5);
    event_clr = 8'h20;
    step(1);
    event_clr = 8'h00;
    check("collide_state", sw_state, 8'h20);
    check("collide_event", sw_event, 8'h20);
    clr_pulse(8'h01);
    check("clr_idle_bit", sw_event, 8'h20);
    clr_pulse(8'h20);
    sw_in = 8'h00;
    step(6);
    check("b5_done_event", sw_event, 8'h00);

    // irq gating with bits 1 and 7
    irq_en = 1'b0;
    sw_in  = 8'h82;
    step(6);
    check("multi_event",  sw_event, 8'h82);
    check("multi_irq_off", irq,     1'b0);
    irq_en = 1'b1;
    #1;
    check("multi_irq_on", irq, 1'b1);
    clr_pulse(8'h02);
    check("multi_clr1_event", sw_event, 8'h80);
    check("multi_clr1_irq",   irq,      1'b1);
    clr_pulse(8'h80);
    check("multi_clr2_event", sw_event, 8'h00);
    check("multi_clr2_irq",   irq,      1'b0);
    sw_in = 8'h00;
    step(6);

    // reset mid-count with a pending event on bit 2
    sw_in = 8'h04;
    step(6);
    check("pre_rst_event", sw_event, 8'h04);
    sw_in = 8'h14;
    step(3);
    rst = 1'b1;
    step(1);
    check("midrst_state", sw_state, 8'h00);
    check("midrst_event", sw_event, 8'h00);
    check("midrst_irq",   irq,      1'b0);
    rst = 1'b0;
    step(5);
    check("post_rst_e5_state", sw_state, 8'h00);
    step(1);
    check("post_rst_e6_state", sw_state, 8'h14);
    check("post_rst_e6_event", sw_event, 8'h14);
    check("post_rst_e6_irq",   irq,      1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
